sd_arbiter: RTL and testbench

- Shares the single HPS SD block channel (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) between NUM_REQ requesters, e.g. fdc drive A, fdc drive B, and a future tape or ROM loader.
- Each requester sees a private SD channel with unchanged semantics: lba and rd/wr held until ack, then byte traffic on buff_* while ack is high.
- The block sits between the MSX core's storage controllers and the hps_io SD port.
- Arbitration is round-robin, one transfer in flight at a time, with an optional watchdog timeout.

---
 rtl/sd_arb_pkg.sv | 12 +
 rtl/sd_arbiter_rr_pick.sv | 29 ++
 rtl/sd_arbiter.sv | 127 ++++++++++++
 tb/tb_sd_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and widths for the SD block-channel arbiter.
package sd_arb_pkg;

  localparam int LBA_W   = 32;
  localparam int BUF_AW  = 9;
  localparam int BUF_DW  = 8;
  localparam int TIMER_W = 24;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, GAP} state_t;
  typedef enum logic {RD = 1'b0, WR = 1'b1} dir_t;

endpackage

// File: rtl/sd_arbiter_rr_pick.sv
// Combinational round-robin pick: first pending index after 'last', wrapping at N.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise paths with no hit infer latches.
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && pending[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_arbiter.sv
// Round-robin share of one host SD block channel between NUM_REQ requesters,
// one transfer in flight, optional watchdog on the host ack.
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter  int                 NUM_REQ = 2,
  parameter  logic [TIMER_W-1:0] TIMEOUT = 24'd0,
  localparam int                 IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [LBA_W*NUM_REQ-1:0]   req_lba,
  input  logic [NUM_REQ-1:0]         req_rd,
  input  logic [NUM_REQ-1:0]         req_wr,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [NUM_REQ-1:0]         req_buff_wr,
  input  logic [BUF_DW*NUM_REQ-1:0]  req_buff_din,
  output logic [BUF_AW-1:0]          req_buff_addr,
  output logic [BUF_DW-1:0]          req_buff_dout,
  output logic                       busy,
  output logic [LBA_W-1:0]           sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic [BUF_AW-1:0]          sd_buff_addr,
  input  logic [BUF_DW-1:0]          sd_buff_dout,
  output logic [BUF_DW-1:0]          sd_buff_din,
  input  logic                       sd_buff_wr
);

  state_t             state;
  dir_t               dir;
  logic [IW-1:0]      grant;
  logic [IW-1:0]      last;
  logic [TIMER_W-1:0] timer;

  logic [IW-1:0]      pick;
  logic               any;
  logic [LBA_W-1:0]   pick_lba;
  logic               pick_rd;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .pending (req_rd | req_wr),
    .last    (last),
    .idx     (pick),
    .any     (any)
  );

  // Per-requester routing is decoded from registered grant/state only.
  always_comb begin
    pick_lba    = '0;
    pick_rd     = 1'b0;
    sd_buff_din = '0;
    req_ack     = '0;
    req_buff_wr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_lba = req_lba[LBA_W*i +: LBA_W];
        pick_rd  = req_rd[i];
      end
      if (grant == IW'(i)) begin
        sd_buff_din    = req_buff_din[BUF_DW*i +: BUF_DW];
        req_ack[i]     = sd_ack && (state == XFER);
        req_buff_wr[i] = sd_buff_wr && (state == XFER);
      end
    end
  end

  assign req_buff_addr = sd_buff_addr;
  assign req_buff_dout = sd_buff_dout;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dir     <= RD;
      grant   <= '0;
      last    <= IW'(NUM_REQ - 1);
      timer   <= '0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      req_err <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so every branch sees the pre-edge state.
      req_err <= '0;
      unique case (state)
        IDLE: if (any) begin
          grant  <= pick;
          sd_lba <= pick_lba;
          dir    <= pick_rd ? RD : WR;
          sd_rd  <= pick_rd;
          sd_wr  <= !pick_rd;
          timer  <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A read+write request is served as read; its write stays pending.
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else if (TIMEOUT != '0 && timer == TIMEOUT - 1'b1) begin
            req_err <= NUM_REQ'(1) << grant;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            last    <= grant;
            state   <= IDLE;
          end else begin
            sd_rd <= (dir == RD);
            sd_wr <= (dir == WR);
            if (timer != '1) timer <= timer + 1'b1;
          end
        end
        XFER: if (!sd_ack) begin
          last  <= grant;
          state <= GAP;
        end
        // One dead cycle lets the requester see its ack fall and drop rd/wr.
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle, plus directed literal checks.
module tb_sd_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [32*N-1:0] req_lba = '0;
  logic [N-1:0]   req_rd = '0;
  logic [N-1:0]   req_wr = '0;
  logic [8*N-1:0] req_buff_din = '0;
  logic           sd_ack = 1'b0;
  logic [8:0]     sd_buff_addr = '0;
  logic [7:0]     sd_buff_dout = '0;
  logic           sd_buff_wr = 1'b0;

  logic [N-1:0]   req_ack, req_err, req_buff_wr;
  logic [8:0]     req_buff_addr;
  logic [7:0]     req_buff_dout, sd_buff_din;
  logic           busy, sd_rd, sd_wr;
  logic [31:0]    sd_lba;

  int checks = 0;
  int failures = 0;
  bit auto_drop = 1'b0;
  logic [N-1:0] prev_seen = '0;

  sd_arbiter #(.NUM_REQ(N), .TIMEOUT(24'(TO))) dut (
    .clk(clk), .reset_n(reset_n),
    .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_ack(req_ack), .req_err(req_err), .req_buff_wr(req_buff_wr),
    .req_buff_din(req_buff_din), .req_buff_addr(req_buff_addr),
    .req_buff_dout(req_buff_dout), .busy(busy),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the channel and which phase the transfer is in.
  int          m_grant = 0;
  int          m_last = N - 1;
  int          m_wait = 0;
  bit          m_ask = 0, m_stream = 0, m_gap = 0, m_rd = 0;
  logic [31:0] m_lba = '0;
  logic [N-1:0] m_err = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_grant = 0; m_last = N - 1; m_wait = 0;
      m_ask = 0; m_stream = 0; m_gap = 0; m_rd = 0;
      m_lba = '0; m_err = '0;
    end else begin
      m_err = '0;
      if (m_gap) m_gap = 0;
      else if (m_stream) begin
        if (!sd_ack) begin m_stream = 0; m_gap = 1; m_last = m_grant; end
      end else if (m_ask) begin
        if (sd_ack) begin m_ask = 0; m_stream = 1; end
        else begin
          m_wait++;
          if (m_wait == TO) begin m_err[m_grant] = 1'b1; m_ask = 0; m_last = m_grant; end
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req_rd[c] || req_wr[c]) begin
            m_grant = c; m_rd = req_rd[c]; m_lba = req_lba[32*c +: 32];
            m_ask = 1; m_wait = 0;
            break;
          end
        end
      end
    end
  end

  int strobes[N];
  int grant_log[$];
  logic [N-1:0] prev_ack = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_ack, e_bwr;
    e_ack = '0;
    e_bwr = '0;
    if (m_stream) begin e_ack[m_grant] = sd_ack; e_bwr[m_grant] = sd_buff_wr; end
    check("m_sd_rd", 32'(sd_rd), 32'(m_ask && m_rd));
    check("m_sd_wr", 32'(sd_wr), 32'(m_ask && !m_rd));
    check("m_sd_lba", sd_lba, m_lba);
    check("m_req_ack", 32'(req_ack), 32'(e_ack));
    check("m_req_buff_wr", 32'(req_buff_wr), 32'(e_bwr));
    check("m_req_err", 32'(req_err), 32'(m_err));
    check("m_busy", 32'(busy), 32'(m_ask || m_stream || m_gap));
    check("m_sd_buff_din", 32'(sd_buff_din), 32'(req_buff_din[8*m_grant +: 8]));
    check("m_buff_addr", 32'(req_buff_addr), 32'(sd_buff_addr));
    check("m_buff_dout", 32'(req_buff_dout), 32'(sd_buff_dout));
    for (int i = 0; i < N; i++) begin
      if (req_buff_wr[i]) strobes[i]++;
      if (req_ack[i] && !prev_ack[i]) grant_log.push_back(i);
    end
    prev_ack = req_ack;
  end

  // Advance one cycle; a requester in auto-drop mode releases rd (else wr) on its ack rising.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (auto_drop && req_ack[i] && !prev_seen[i]) begin
        if (req_rd[i]) req_rd[i] = 1'b0;
        else req_wr[i] = 1'b0;
      end
    end
    prev_seen = req_ack;
  endtask

  task automatic serve(input int lag, input int nbytes, output logic rd_s,
                       output logic wr_s, output logic [31:0] lba_s);
    int n = 0;
    while (!sd_rd && !sd_wr && n < 100) begin tick(); n++; end
    check("serve_start_bound", 32'(sd_rd || sd_wr), 32'd1);
    rd_s = sd_rd; wr_s = sd_wr; lba_s = sd_lba;
    repeat (lag) tick();
    sd_ack = 1'b1;
    tick();
    for (int b = 0; b < nbytes; b++) begin
      sd_buff_addr = 9'(b); sd_buff_dout = 8'($urandom); sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic quiesce();
    req_rd = '0; req_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic rd_s, wr_s;
    logic [31:0] lba_s;
    int s0, s1, base, n;
    int exp_g[4];
    logic [31:0] exp_l[4];
    logic [1:0] r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_rd", 32'(sd_rd), 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    auto_drop = 1'b1;

    // Single read from requester 0.
    req_lba[31:0] = 32'h12; req_rd = 2'b01;
    tick();
    check("rd_sd_rd", 32'(sd_rd), 32'd1);
    check("rd_sd_lba", sd_lba, 32'h12);
    repeat (4) tick();
    sd_ack = 1'b1;
    tick();
    check("rd_drop", 32'(sd_rd), 32'd0);
    check("rd_ack", 32'(req_ack), 32'b01);
    s0 = strobes[0]; s1 = strobes[1];
    for (int b = 0; b < 512; b++) begin
      sd_buff_addr = 9'(b); sd_buff_dout = 8'($urandom); sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    tick();
    check("rd_gap_busy", 32'(busy), 32'd1);
    tick();
    check("rd_idle_busy", 32'(busy), 32'd0);
    check("rd_strobes0", 32'(strobes[0] - s0), 32'd512);
    check("rd_strobes1", 32'(strobes[1] - s1), 32'd0);
    quiesce();

    // Write from requester 1.
    req_buff_din = {8'hA5, 8'h00}; req_lba[63:32] = 32'h77; req_wr = 2'b10;
    n = 0;
    while (!sd_wr && n < 20) begin tick(); n++; end
    check("wr_sd_wr", 32'(sd_wr), 32'd1);
    check("wr_sd_rd", 32'(sd_rd), 32'd0);
    sd_ack = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      sd_buff_wr = 1'b1;
      #1;
      check("wr_din", 32'(sd_buff_din), 32'hA5);
      check("wr_ack", 32'(req_ack), 32'b10);
      tick();
      sd_buff_wr = 1'b0;
    end
    sd_ack = 1'b0;
    tick();
    quiesce();

    // Fairness with both reads held continuously.
    auto_drop = 1'b0;
    req_lba = {32'hBBBB_0001, 32'hAAAA_0000};
    req_rd = 2'b11;
    base = grant_log.size();
    exp_g = '{0, 1, 0, 1};
    exp_l = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hAAAA_0000, 32'hBBBB_0001};
    for (int t = 0; t < 4; t++) begin
      serve(2, 3, rd_s, wr_s, lba_s);
      check("fair_lba", lba_s, exp_l[t]);
    end
    req_rd = 2'b00;
    auto_drop = 1'b1;
    check("fair_count", 32'(grant_log.size() - base), 32'd4);
    for (int t = 0; t < 4; t++)
      if (base + t < grant_log.size()) check("fair_grant", 32'(grant_log[base+t]), 32'(exp_g[t]));
    quiesce();

    // Watchdog: no ack on requester 0.
    req_rd = 2'b01;
    tick();
    check("wd_sd_rd", 32'(sd_rd), 32'd1);
    n = 0;
    while (!req_err[0] && n < 40) begin tick(); n++; end
    check("wd_delay", 32'(n), 32'd16);
    check("wd_sd_rd_drop", 32'(sd_rd), 32'd0);
    check("wd_idle", 32'(busy), 32'd0);
    tick();
    check("wd_pulse", 32'(req_err), 32'd0);
    check("wd_regrant", 32'(sd_rd), 32'd1);
    serve(1, 2, rd_s, wr_s, lba_s);
    quiesce();

    // Reset in the middle of a transfer.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    auto_drop = 1'b0;
    req_lba = {32'h0000_0B0B, 32'h0000_0A0A};
    req_rd = 2'b11;
    tick();
    check("rst_first_lba", sd_lba, 32'h0A0A);
    sd_ack = 1'b1;
    tick();
    check("rst_pre_ack", 32'(req_ack), 32'b01);
    sd_buff_wr = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_mid_rd", 32'(sd_rd), 32'd0);
    check("rst_mid_ack", 32'(req_ack), 32'd0);
    check("rst_mid_bwr", 32'(req_buff_wr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
    reset_n = 1'b1;
    serve(1, 2, rd_s, wr_s, lba_s);
    check("rst_regrant_lba", lba_s, 32'h0A0A);
    req_rd = 2'b00;
    auto_drop = 1'b1;
    quiesce();

    // Read and write together on requester 0.
    req_lba[31:0] = 32'h0000_0C0C;
    req_rd = 2'b01; req_wr = 2'b01;
    serve(1, 2, rd_s, wr_s, lba_s);
    check("rw_first_rd", 32'(rd_s), 32'd1);
    serve(1, 2, rd_s, wr_s, lba_s);
    check("rw_second_wr", 32'(wr_s), 32'd1);
    check("rw_second_rd", 32'(rd_s), 32'd0);
    quiesce();

    // Randomized traffic with occasional watchdog aborts.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_rd[i] && !req_wr[i] && $urandom_range(0, 1) == 1) begin
          req_lba[32*i +: 32] = $urandom;
          req_buff_din[8*i +: 8] = 8'($urandom);
          r = 2'($urandom_range(1, 3));
          req_rd[i] = r[0]; req_wr[i] = r[1];
        end
      end
      if (req_rd == '0 && req_wr == '0) req_rd[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        n = 0;
        while (req_err == '0 && n < 40) begin tick(); n++; end
        check("rand_wd_bound", 32'(req_err != '0), 32'd1);
      end else begin
        serve($urandom_range(0, 10), $urandom_range(1, 6), rd_s, wr_s, lba_s);
      end
    end
    quiesce();
    check("end_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
